// File: rtl/tqvp_bg_compositor_if.sv
// TinyQV peripheral bus bundle for the background compositor.
// The master drives address/write/read strobes and the slave returns read data.
interface tqvp_bg_compositor_if;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output address, data_in, data_write_n, data_read_n,
      input  data_out, data_ready
   );

   modport slave (
      input  address, data_in, data_write_n, data_read_n,
      output data_out, data_ready
   );
endinterface

// File: rtl/tqvp_bg_compositor.sv
// Multi-layer background compositor: register file, per-frame scrolling and priority compositing.
// Define BGC_AUTOSCROLL_EN to add per-layer velocity registers applied on each frame tick.
module tqvp_bg_compositor #(
   parameter int NUM_LAYERS = 3,
   parameter int OFFS_W     = 11
) (
   input  logic                         clk,
   input  logic                         rst,
   tqvp_bg_compositor_if.slave          bus,
   input  logic                         hsync,
   input  logic                         vsync,
   input  logic                         visible,
   input  logic [6*NUM_LAYERS-1:0]      layer_rgb,
   input  logic [NUM_LAYERS-1:0]        layer_opaque,
   output logic [OFFS_W*NUM_LAYERS-1:0] scroll_x,
   output logic [OFFS_W*NUM_LAYERS-1:0] scroll_y,
   output logic [7:0]                   uo_out,
   output logic                         user_interrupt
);

   logic                  run;
   logic                  irq_en;
   logic                  pending;
   logic                  vsync_q;
   logic [NUM_LAYERS-1:0] layer_en;
   logic [7:0]            irq_div;
   logic [7:0]            div_cnt;
   logic [7:0]            uo_q;
   logic [15:0]           frame_cnt;
   logic [5:0]            backdrop;
   logic [5:0]            pix_next;
   logic [OFFS_W-1:0]     offs_x [NUM_LAYERS];
   logic [OFFS_W-1:0]     offs_y [NUM_LAYERS];
`ifdef BGC_AUTOSCROLL_EN
   logic [7:0]            vel_x  [NUM_LAYERS];
   logic [7:0]            vel_y  [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] vel_wr;
`endif

   logic                  wr_en;
   logic [31:0]           wmask;
   logic [2:0]            sel_idx;
   logic                  layer_hit;
   logic                  ctrl_wr;
   logic                  status_wr;
   logic                  backdrop_wr;
   logic [NUM_LAYERS-1:0] offs_wr;
   logic                  run_eff;
   logic                  tick;
   logic                  advance;
   logic                  irq_hit;
   logic [31:0]           rdata;
   logic                  unused_bus;

   assign unused_bus = ^{bus.address[1:0], bus.data_read_n, bus.data_in};

   // A CTRL write landing in the tick cycle decides whether that tick counts.
   always_comb begin
      wr_en       = (bus.data_write_n != 2'b11);
      case (bus.data_write_n)
         2'b00:   wmask = 32'h0000_00FF;
         2'b01:   wmask = 32'h0000_FFFF;
         2'b10:   wmask = 32'hFFFF_FFFF;
         default: wmask = 32'h0000_0000;
      endcase
      sel_idx     = bus.address[5:3] - 3'd2;
      layer_hit   = (bus.address[5:4] != 2'b00);
      ctrl_wr     = wr_en && (bus.address[5:2] == 4'h0);
      status_wr   = wr_en && (bus.address[5:2] == 4'h1);
      backdrop_wr = wr_en && (bus.address[5:2] == 4'h3);
      offs_wr     = '0;
`ifdef BGC_AUTOSCROLL_EN
      vel_wr      = '0;
`endif
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (wr_en && layer_hit && (sel_idx == 3'(i))) begin
            if (!bus.address[2]) begin
               offs_wr[i] = 1'b1;
            end
`ifdef BGC_AUTOSCROLL_EN
            else begin
               vel_wr[i] = 1'b1;
            end
`endif
         end
      end
      run_eff = ctrl_wr ? bus.data_in[0] : run;
      tick    = vsync & ~vsync_q;
      advance = tick & run_eff;
      irq_hit = advance && (div_cnt == irq_div);
   end

   always_comb begin
      rdata = '0;
      case (bus.address[5:2])
         4'h0: begin
            rdata[0]              = run;
            rdata[1]              = irq_en;
            rdata[8 +: NUM_LAYERS] = layer_en;
            rdata[23:16]          = irq_div;
         end
         4'h1: rdata[0]    = pending;
         4'h2: rdata[15:0] = frame_cnt;
         4'h3: rdata[5:0]  = backdrop;
         default: begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
               if (layer_hit && (sel_idx == 3'(i))) begin
                  if (!bus.address[2]) begin
                     rdata[OFFS_W-1:0]   = offs_x[i];
                     rdata[16 +: OFFS_W] = offs_y[i];
                  end
`ifdef BGC_AUTOSCROLL_EN
                  else begin
                     rdata[7:0]  = vel_x[i];
                     rdata[15:8] = vel_y[i];
                  end
`endif
               end
            end
         end
      endcase
   end

   assign bus.data_out   = rdata;
   assign bus.data_ready = 1'b1;

   // Walking from the highest index down lets the lowest-index qualifying layer win.
   always_comb begin
      pix_next = 6'd0;
      if (run && visible) begin
         pix_next = backdrop;
         for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && layer_opaque[i]) begin
               pix_next = layer_rgb[6*i +: 6];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run       <= 1'b0;
         irq_en    <= 1'b0;
         pending   <= 1'b0;
         vsync_q   <= 1'b0;
         layer_en  <= '0;
         irq_div   <= 8'd0;
         div_cnt   <= 8'd0;
         uo_q      <= 8'd0;
         frame_cnt <= 16'd0;
         backdrop  <= 6'd0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            offs_x[i] <= '0;
            offs_y[i] <= '0;
`ifdef BGC_AUTOSCROLL_EN
            vel_x[i]  <= 8'd0;
            vel_y[i]  <= 8'd0;
`endif
         end
      end else begin
         vsync_q <= vsync;
         uo_q    <= {vsync, hsync, pix_next};

         if (ctrl_wr) begin
            run    <= bus.data_in[0];
            irq_en <= bus.data_in[1];
            if (wmask[8]) layer_en <= bus.data_in[8 +: NUM_LAYERS];
            if (wmask[16]) irq_div <= bus.data_in[23:16];
         end
         if (backdrop_wr) backdrop <= bus.data_in[5:0];

         if (advance) frame_cnt <= frame_cnt + 16'd1;

         if (!run_eff || irq_hit) begin
            div_cnt <= 8'd0;
         end else if (advance) begin
            div_cnt <= div_cnt + 8'd1;
         end

         // The interrupt set outranks a simultaneous write-one-to-clear.
         if (irq_hit) begin
            pending <= 1'b1;
         end else if (status_wr && bus.data_in[0]) begin
            pending <= 1'b0;
         end

         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (offs_wr[i]) begin
               offs_x[i] <= (offs_x[i] & ~wmask[OFFS_W-1:0])
                          | (bus.data_in[OFFS_W-1:0] & wmask[OFFS_W-1:0]);
               offs_y[i] <= (offs_y[i] & ~wmask[16 +: OFFS_W])
                          | (bus.data_in[16 +: OFFS_W] & wmask[16 +: OFFS_W]);
            end
`ifdef BGC_AUTOSCROLL_EN
            else if (advance && layer_en[i]) begin
               offs_x[i] <= offs_x[i] + OFFS_W'($signed(vel_x[i]));
               offs_y[i] <= offs_y[i] + OFFS_W'($signed(vel_y[i]));
            end
            if (vel_wr[i]) begin
               vel_x[i] <= bus.data_in[7:0];
               if (wmask[8]) vel_y[i] <= bus.data_in[15:8];
            end
`endif
         end
      end
   end

   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_scroll
      assign scroll_x[g*OFFS_W +: OFFS_W] = offs_x[g];
      assign scroll_y[g*OFFS_W +: OFFS_W] = offs_y[g];
   end

   assign uo_out         = rst ? 8'd0 : uo_q;
   assign user_interrupt = pending & irq_en;

endmodule
